// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - State encoding, frame length and tstrb codes for uart_stream_receive.
// UART_RX_PARITY_EN selects the 8E1 frame and adds the PARITY state.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_t;

`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic [1:0] STRB_FULL = 2'b11;
  localparam logic [1:0] STRB_HIGH = 2'b10;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [1:0]  strb;
  } beat_t;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - Synchronous FIFO with full/empty flags; head entry is read from registers.
module stream_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_stream_receive.sv
// rtl/uart_stream_receive.sv - UART receiver packing byte pairs into 16-bit AXI-Stream words.
// Define UART_RX_PARITY_EN for 8E1 framing with parity check; default is 8N1.
module uart_stream_receive
  import uart_rx_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE         = 12_500_000,
  parameter int FIFO_DEPTH        = 4,
  parameter int IDLE_TIMEOUT_BITS = 16
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  input  logic        rx_wire_in,
  input  logic        m00_axis_tready,
  output logic        m00_axis_tvalid,
  output logic [15:0] m00_axis_tdata,
  output logic        m00_axis_tlast,
  output logic [1:0]  m00_axis_tstrb,
  output logic        frame_err_out,
  output logic        overflow_out
);
  localparam int CYCLES_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int ARM_CYCLES     = FRAME_BITS * CYCLES_PER_BIT;
  localparam int TO_CYCLES      = IDLE_TIMEOUT_BITS * CYCLES_PER_BIT;
  localparam int CW             = $clog2(CYCLES_PER_BIT + 1);
  localparam int AW             = $clog2(ARM_CYCLES + 1);
  localparam int TW             = $clog2(TO_CYCLES + 1);

  if (CYCLES_PER_BIT < 4) begin : g_cpb_check
    $error("CYCLES_PER_BIT must be at least 4");
  end

  rx_state_t   r_state, w_next_state;
  logic        r_rx_meta, r_rx_s, r_rx_d;
  logic [CW-1:0] r_cyc_cnt;
  logic [AW-1:0] r_arm_cnt;
  logic [TW-1:0] r_idle_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift, r_lone;
  logic [15:0] r_pending;
  logic        r_lone_valid, r_pending_valid, r_to_fired;
  logic        r_push_valid, r_frame_err, r_overflow;
  beat_t       r_push_beat, w_head;
  logic        w_fall, w_sample, w_byte_ok, w_bad_frame, w_to_hit;
  logic        w_full, w_empty, w_pop;

  assign w_fall   = r_rx_d && !r_rx_s;
  assign w_to_hit = (r_state == ST_IDLE) && !r_to_fired && (r_idle_cnt == TW'(TO_CYCLES));
  assign w_pop    = m00_axis_tready && !w_empty;

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) r_state <= ST_ARM;
    else                   r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_sample     = 1'b0;
    w_byte_ok    = 1'b0;
    w_bad_frame  = 1'b0;
    case (r_state)
      ST_ARM:   if (r_rx_s && r_arm_cnt == AW'(ARM_CYCLES - 1)) w_next_state = ST_IDLE;
      ST_IDLE:  if (w_fall) w_next_state = ST_START;
      ST_START: if (r_cyc_cnt == CW'(HALF_BIT)) begin
        w_sample     = 1'b1;
        w_next_state = r_rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA:  if (r_cyc_cnt == CW'(CYCLES_PER_BIT - 1)) begin
        w_sample = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (r_bit_cnt == 3'd7) w_next_state = ST_PARITY;
`else
        if (r_bit_cnt == 3'd7) w_next_state = ST_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (r_cyc_cnt == CW'(CYCLES_PER_BIT - 1)) begin
        w_sample = 1'b1;
        if (r_rx_s != ^r_shift) begin
          w_bad_frame  = 1'b1;
          w_next_state = ST_ARM;
        end else begin
          w_next_state = ST_STOP;
        end
      end
`endif
      ST_STOP:  if (r_cyc_cnt == CW'(CYCLES_PER_BIT - 1)) begin
        w_sample     = 1'b1;
        w_byte_ok    = r_rx_s;
        w_bad_frame  = !r_rx_s;
        w_next_state = r_rx_s ? ST_IDLE : ST_ARM;
      end
      default:  w_next_state = ST_ARM;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_rx_meta       <= 1'b1;
      r_rx_s          <= 1'b1;
      r_rx_d          <= 1'b1;
      r_cyc_cnt       <= '0;
      r_arm_cnt       <= '0;
      r_idle_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_lone          <= '0;
      r_pending       <= '0;
      r_lone_valid    <= 1'b0;
      r_pending_valid <= 1'b0;
      r_to_fired      <= 1'b0;
      r_push_valid    <= 1'b0;
      r_push_beat     <= '0;
      r_frame_err     <= 1'b0;
      r_overflow      <= 1'b0;
    end else begin
      r_rx_meta   <= rx_wire_in;
      r_rx_s      <= r_rx_meta;
      r_rx_d      <= r_rx_s;
      r_frame_err <= w_bad_frame;
      r_overflow  <= r_overflow || (r_push_valid && w_full && !w_pop);
      r_arm_cnt   <= (r_state == ST_ARM && r_rx_s) ? r_arm_cnt + 1'b1 : '0;

      // Loading 1 while idle makes the detect cycle count as the first cycle of the start bit.
      if (r_state == ST_IDLE) r_cyc_cnt <= CW'(1);
      else if (w_sample)      r_cyc_cnt <= '0;
      else                    r_cyc_cnt <= r_cyc_cnt + 1'b1;

      if (r_state == ST_START)           r_bit_cnt <= '0;
      else if (r_state == ST_DATA && w_sample) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_shift   <= {r_rx_s, r_shift[7:1]};
      end

      if (w_fall) begin
        r_idle_cnt <= '0;
        r_to_fired <= 1'b0;
      end else begin
        if (r_state == ST_IDLE && r_idle_cnt != TW'(TO_CYCLES)) r_idle_cnt <= r_idle_cnt + 1'b1;
        // With both a word and a lone byte held, the timer fires again next cycle for the byte.
        if (w_to_hit && !(r_pending_valid && r_lone_valid)) r_to_fired <= 1'b1;
      end

      r_push_valid <= 1'b0;
      if (w_byte_ok) begin
        if (!r_lone_valid) begin
          r_lone       <= r_shift;
          r_lone_valid <= 1'b1;
        end else begin
          r_lone_valid    <= 1'b0;
          r_pending       <= {r_lone, r_shift};
          r_pending_valid <= 1'b1;
          if (r_pending_valid) begin
            r_push_valid <= 1'b1;
            r_push_beat  <= {r_pending, 1'b0, STRB_FULL};
          end
        end
      end else if (w_to_hit) begin
        if (r_pending_valid) begin
          r_push_valid    <= 1'b1;
          r_push_beat     <= {r_pending, !r_lone_valid, STRB_FULL};
          r_pending_valid <= 1'b0;
        end else if (r_lone_valid) begin
          r_push_valid <= 1'b1;
          r_push_beat  <= {r_lone, 8'h00, 1'b1, STRB_HIGH};
          r_lone_valid <= 1'b0;
        end
      end
    end
  end

  stream_fifo #(
    .WIDTH($bits(beat_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (m00_axis_aclk),
    .rst_n  (m00_axis_aresetn),
    .i_push (r_push_valid),
    .i_data (r_push_beat),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign m00_axis_tvalid = !w_empty;
  assign m00_axis_tdata  = w_head.data;
  assign m00_axis_tlast  = w_head.last;
  assign m00_axis_tstrb  = w_head.strb;
  assign frame_err_out   = r_frame_err;
  assign overflow_out    = r_overflow;

endmodule

// File: tb/tb_uart_stream_receive.sv
// tb/tb_uart_stream_receive.sv - Directed bench for uart_stream_receive at 4 clocks per bit.
module tb_uart_stream_receive;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        tready;
  logic        tvalid;
  logic [15:0] tdata;
  logic        tlast;
  logic [1:0]  tstrb;
  logic        ferr;
  logic        ovf;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_ferr   = 0;
  logic [18:0] q[$];

  always #5 clk = ~clk;

  uart_stream_receive #(
    .INPUT_CLOCK_FREQ (50_000_000),
    .BAUD_RATE        (12_500_000),
    .FIFO_DEPTH       (4),
    .IDLE_TIMEOUT_BITS(16)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .rx_wire_in      (rx),
    .m00_axis_tready (tready),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tdata  (tdata),
    .m00_axis_tlast  (tlast),
    .m00_axis_tstrb  (tstrb),
    .frame_err_out   (ferr),
    .overflow_out    (ovf)
  );

  always @(negedge clk) begin
    if (tvalid && tready) q.push_back({tdata, tlast, tstrb});
    if (ferr) n_ferr++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_v);
    rx = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (q.size() < n && c < budget) begin
      tick(1);
      c++;
    end
  endtask

  task automatic check_beat(input string tag, input logic [15:0] d, input logic l, input logic [1:0] s);
    logic [18:0] b;
    if (q.size() > 0) b = q.pop_front();
    else              b = 'x;
    check({tag, " tdata"}, 32'(b[18:3]), 32'(d));
    check({tag, " tlast"}, 32'(b[2]), 32'(l));
    check({tag, " tstrb"}, 32'(b[1:0]), 32'(s));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    rx     = 1'b1;
    tready = 1'b1;
    tick(3);
    check("reset outputs", 32'({tvalid, tdata, tlast, tstrb, ferr, ovf}), 32'd0);
    rst_n = 1'b1;
    tick(12 * CPB);

    // Two bytes then idle: single word flushed by the timeout
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    wait_beats(1, 300);
    check("t1 beat count", q.size(), 32'd1);
    check_beat("t1 beat", 16'hABCD, 1'b1, 2'b11);
    tick(20);
    check("t1 no extra beat", q.size(), 32'd0);

    // Four bytes: first word displaced with tlast=0, second flushed with tlast=1
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_beats(2, 300);
    check("t2 beat count", q.size(), 32'd2);
    check_beat("t2 beat0", 16'hABCD, 1'b0, 2'b11);
    check_beat("t2 beat1", 16'h1234, 1'b1, 2'b11);

    // Lone byte padded on timeout
    send_byte(8'h5A, 1'b1);
    wait_beats(1, 300);
    check("t3 beat count", q.size(), 32'd1);
    check_beat("t3 beat", 16'h5A00, 1'b1, 2'b10);

    // Glitch is a false start; bad stop bit pulses frame error and drops the byte
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(40);
    check("t4 glitch no beat", q.size(), 32'd0);
    check("t4 glitch no ferr", n_ferr, 32'd0);
    send_byte(8'h77, 1'b0);
    tick(14 * CPB);
    check("t4 ferr pulse cycles", n_ferr, 32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_beats(1, 300);
    check("t4 beat count", q.size(), 32'd1);
    check_beat("t4 beat", 16'h1122, 1'b1, 2'b11);
    check("t4 overflow clear", ovf, 32'd0);

    // Backpressure: FIFO fills with words 1..4, word 5 dropped when word 6 completes
    tready = 1'b0;
    for (int w = 1; w <= 6; w++) begin
      send_byte(8'h00, 1'b1);
      send_byte(8'(w), 1'b1);
      if (w == 5) check("t5 overflow before word6", ovf, 32'd0);
    end
    tick(8);
    check("t5 overflow set", ovf, 32'd1);
    check("t5 no pops while stalled", q.size(), 32'd0);
    check("t5 tvalid held", tvalid, 32'd1);
    check("t5 stalled tdata", tdata, 32'h0001);
    check("t5 stalled tlast", tlast, 32'd0);
    check("t5 stalled tstrb", tstrb, 32'd3);
    tready = 1'b1;
    wait_beats(5, 300);
    check("t5 beat count", q.size(), 32'd5);
    check_beat("t5 beat0", 16'h0001, 1'b0, 2'b11);
    check_beat("t5 beat1", 16'h0002, 1'b0, 2'b11);
    check_beat("t5 beat2", 16'h0003, 1'b0, 2'b11);
    check_beat("t5 beat3", 16'h0004, 1'b0, 2'b11);
    check_beat("t5 beat4", 16'h0006, 1'b1, 2'b11);
    check("t5 overflow sticky", ovf, 32'd1);

    // Reset in data bit 3 of 0x99, then finish the frame while the receiver re-arms
    q.delete();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    check("t6 reset outputs", 32'({tvalid, tdata, tlast, tstrb, ferr, ovf}), 32'd0);
    rst_n = 1'b1;
    tick(2);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    tick(4);
    check("t6 no beat after reset", q.size(), 32'd0);
    tick(12 * CPB);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    wait_beats(1, 300);
    check("t6 beat count", q.size(), 32'd1);
    check_beat("t6 beat", 16'hAABB, 1'b1, 2'b11);
    check("t6 no frame error", n_ferr, 32'd1);
    tick(20);
    check("t6 no extra beat", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
